data_mem_access_unit: RTL and testbench

- Initiator side of the data-memory port: converts CPU load/store requests into address/data/wren cycles on the DataMemSection single-port RAM.
- RAM is 16-bit word-addressed, 32-bit data, with registered address and no byte enables.
- Handles byte, half-word and word accesses. Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Sits between the pipeline MEM stage and DataMemSection.

---
 rtl/data_mem_access_unit_if.sv | 41 ++++
 rtl/data_mem_access_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_unit_if.sv
// Request/response bus between the MEM stage and the data-memory access unit,
// plus the word-addressed RAM port the unit drives.
interface data_mem_access_unit_if #(
  parameter int ADDR_W = 16
);
  // CPU-side request channel
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_signed_i;
  logic [31:0]       req_addr_i;
  logic [31:0]       req_wdata_i;

  // CPU-side completion channel
  logic              resp_valid_o;
  logic [31:0]       resp_rdata_o;
  logic              resp_err_o;

  // RAM port
  logic [ADDR_W-1:0] mem_address_o;
  logic [31:0]       mem_data_o;
  logic              mem_wren_o;
  logic [31:0]       mem_q_i;

  // The access unit: accepts requests, drives the RAM
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i,
           req_wdata_i, mem_q_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_address_o, mem_data_o, mem_wren_o
  );

  // The environment: pipeline requester plus RAM model
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i,
           req_wdata_i, mem_q_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_address_o, mem_data_o, mem_wren_o
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Data-memory access unit: turns byte/half/word load/store requests into
// cycles on a 32-bit word-addressed single-port RAM with registered address.
// Sub-word stores are read-modify-write; loads are sign/zero-extended.
module data_mem_access_unit #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1   // 1..3
) (
  input logic                   CLK,
  input logic                   reset,
  data_mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ADDR,
    S_LD_WAIT,
    S_RMW_RD,
    S_RMW_WAIT,
    S_WR,
    S_RESP
  } state_e;

  localparam int                CNT_W    = 2;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(READ_LAT - 1);
  // Byte-address bits above the RAM's reach; any of them set is an error.
  localparam logic [31:0]       HI_MASK  = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  // Request fields latched at accept
  size_e             size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;

  logic              req_ready;
  logic              accept;
  logic              req_err;
  size_e             req_size;

  // Select the addressed lane of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input size_e     size,
                                               input logic [1:0] lane,
                                               input logic      sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace the addressed lane of the old RAM word with the new store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input size_e     size,
                                              input logic [1:0] lane,
                                              input logic [15:0] data);
    store_merge = old_word;
    if (size == SZ_BYTE) begin
      store_merge[{lane, 3'b000} +: 8] = data[7:0];
    end else if (lane[1]) begin
      store_merge[31:16] = data;
    end else begin
      store_merge[15:0] = data;
    end
  endfunction

  assign req_size  = size_e'(bus.req_size_i);
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = bus.req_valid_i && req_ready;

  assign req_err = (req_size == SZ_ILL)
                || ((req_size == SZ_HALF) && bus.req_addr_i[0])
                || ((req_size == SZ_WORD) && (bus.req_addr_i[1:0] != 2'b00))
                || ((bus.req_addr_i & HI_MASK) != 32'd0);

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                   state_d = S_RESP;
          else if (!bus.req_we_i)        state_d = S_LD_ADDR;
          else if (req_size == SZ_WORD)  state_d = S_WR;
          else                           state_d = S_RMW_RD;
        end
      end
      S_LD_ADDR:  state_d = S_LD_WAIT;
      S_LD_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RMW_RD:   state_d = S_RMW_WAIT;
      S_RMW_WAIT: if (cnt_q == '0) state_d = S_WR;
      S_WR:       state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Next values of the registered RAM/response outputs and the latency counter
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_address_d = bus.req_addr_i[ADDR_W+1:2];
            if (bus.req_we_i && (req_size == SZ_WORD)) begin
              mem_data_d = bus.req_wdata_i;
              mem_wren_d = 1'b1;
            end
          end
        end
      end
      S_LD_ADDR, S_RMW_RD: cnt_d = CNT_INIT;
      S_LD_WAIT: begin
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_extract(bus.mem_q_i, size_q, lane_q, signed_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RMW_WAIT: begin
        if (cnt_q == '0) begin
          mem_data_d = store_merge(bus.mem_q_i, size_q, lane_q, wdata_q);
          mem_wren_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Capture request fields at accept
  // NOTE: these data-path holding registers carry no reset; they are only read
  // in states that can be reached solely through an accept that loads them.
  always_ff @(posedge CLK) begin
    if (accept) begin
      size_q   <= req_size;
      signed_q <= bus.req_signed_i;
      lane_q   <= bus.req_addr_i[1:0];
      wdata_q  <= bus.req_wdata_i[15:0];
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.mem_address_o = mem_address_q;
  assign bus.mem_data_o    = mem_data_q;
  assign bus.mem_wren_o    = mem_wren_q;
  assign bus.resp_valid_o  = resp_valid_q;
  assign bus.resp_rdata_o  = resp_rdata_q;
  assign bus.resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed requests, a RAM model with
// registered address, and a reference model of memory contents that predicts
// every response and every RAM write.
module tb_data_mem_access_unit;

  localparam int ADDR_W   = 16;
  localparam int READ_LAT = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_access_unit #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM: registered address, data one cycle after the address is sampled
  logic [31:0]       ram [0:65535];
  logic [ADDR_W-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (bus.mem_wren_o) ram[bus.mem_address_o] <= bus.mem_data_o;
    ram_addr_q <= bus.mem_address_o;
  end
  assign bus.mem_q_i = ram[ram_addr_q];

  // Reference memory contents as the unit should leave them
  logic [31:0] ref_mem [0:65535];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        wr;
    logic [15:0] waddr;
    logic [31:0] wdata;
  } model_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  resp_exp_t exp_resp_q[$];
  wr_exp_t   exp_wr_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_resp = 0;
  bit monitor_on = 0;
  bit b2b_mode = 0;
  bit b2b_armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // What a request must produce, from byte-address arithmetic on ref_mem
  function automatic model_t model_eval(input logic we, input logic [1:0] size,
                                        input logic sgn, input logic [31:0] addr,
                                        input logic [31:0] wdata);
    model_t      m;
    logic [63:0] a, mask, old, nw, v;
    int          shift, waddr;
    m = '{rdata: '0, err: 1'b0, lat: 0, wr: 1'b0, waddr: '0, wdata: '0};
    a     = {32'd0, addr};
    shift = int'(a % 4) * 8;
    waddr = int'((a / 4) % 65536);
    mask  = (size == 2'd0) ? 64'hFF : (size == 2'd1) ? 64'hFFFF : 64'hFFFF_FFFF;
    m.err = (size == 2'd3) || (size == 2'd1 && (a % 2) != 0)
         || (size == 2'd2 && (a % 4) != 0) || (a >= (64'd1 << (ADDR_W + 2)));
    if (m.err) begin
      m.lat = 1;
    end else if (we) begin
      old     = {32'd0, ref_mem[waddr]};
      nw      = (old & ~(mask << shift)) | (({32'd0, wdata} & mask) << shift);
      m.wr    = 1'b1;
      m.waddr = waddr[15:0];
      m.wdata = nw[31:0];
      m.lat   = (size == 2'd2) ? 2 : 4;
    end else begin
      v = ({32'd0, ref_mem[waddr]} >> shift) & mask;
      if (sgn && size != 2'd2 && (v & ((mask + 1) >> 1)) != 0) v = v | ~mask;
      m.rdata = v[31:0];
      m.lat   = 3;
    end
    return m;
  endfunction

  // Present a request (called at a negedge) and return at the negedge after accept
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit expect_resp, input bit hold);
    model_t m;
    bit     accepted;
    accepted = 0;
    m = model_eval(we, size, sgn, addr, wdata);
    if (expect_resp) begin
      exp_resp_q.push_back(resp_exp_t'{m.rdata, m.err, m.lat});
      if (m.wr) begin
        exp_wr_q.push_back(wr_exp_t'{m.waddr, m.wdata});
        ref_mem[m.waddr] = m.wdata;
      end
    end
    bus.req_we_i     = we;
    bus.req_size_i   = size;
    bus.req_signed_i = sgn;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    bus.req_valid_i  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready_o) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) fail("accept_timeout");
    else @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (exp_resp_q.size() == 0 && exp_wr_q.size() == 0) return;
      @(negedge clk);
    end
    fail("response_timeout");
  endtask

  // Compare process: RAM writes and responses against the model, every cycle
  initial begin
    resp_exp_t r;
    wr_exp_t   w;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (monitor_on && !reset) begin
        if (bus.req_valid_i && bus.req_ready_o) begin
          if (b2b_mode && b2b_armed) check("b2b_accept_gap", cyc - last_resp, 1);
          last_acc = cyc;
        end
        if (bus.mem_wren_o) begin
          if (exp_wr_q.size() == 0) begin
            fail("unexpected_write");
          end else begin
            w = exp_wr_q.pop_front();
            check("write_addr", 32'(bus.mem_address_o), 32'(w.addr));
            check("write_data", bus.mem_data_o, w.data);
          end
        end
        if (bus.resp_valid_o) begin
          if (exp_resp_q.size() == 0) begin
            fail("unexpected_resp");
          end else begin
            r = exp_resp_q.pop_front();
            check("resp_err", 32'(bus.resp_err_o), 32'(r.err));
            check("resp_rdata", bus.resp_rdata_o, r.rdata);
            check("resp_latency", cyc - last_acc, r.lat);
          end
          last_resp = cyc;
          if (b2b_mode) b2b_armed = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    reset            = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_size_i   = 2'b00;
    bus.req_signed_i = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_address", 32'(bus.mem_address_o), 32'h0);
    check("rst_mem_data", bus.mem_data_o, 32'h0);
    check("rst_mem_wren", 32'(bus.mem_wren_o), 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid_o), 32'h0);
    check("rst_resp_rdata", bus.resp_rdata_o, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err_o), 32'h0);
    check("rst_ready_low", 32'(bus.req_ready_o), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_ready", 32'(bus.req_ready_o), 32'h1);
    monitor_on = 1;
    @(negedge clk);

    // Word store then word load
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 0);
    wait_done();
    check("ram_word_store", ram[4], 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1, 0);
    wait_done();

    // Byte read-modify-write
    issue(1, 2'b10, 0, 32'h20, 32'h11223344, 1, 0);
    wait_done();
    check("pin_model_merge", model_eval(1, 2'b00, 0, 32'h21, 32'hAA).wdata, 32'h1122AA44);
    issue(1, 2'b00, 0, 32'h21, 32'h000000AA, 1, 0);
    wait_done();
    check("ram_rmw_byte", ram[8], 32'h1122AA44);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 1, 0);
    wait_done();

    // Sub-word loads with extension
    issue(1, 2'b10, 0, 32'h30, 32'h8000F0FF, 1, 0);
    wait_done();
    check("pin_half_signed", model_eval(0, 2'b01, 1, 32'h32, 0).rdata, 32'hFFFF8000);
    check("pin_half_unsigned", model_eval(0, 2'b01, 0, 32'h32, 0).rdata, 32'h00008000);
    check("pin_byte_signed", model_eval(0, 2'b00, 1, 32'h30, 0).rdata, 32'hFFFFFFFF);
    check("pin_byte_unsigned", model_eval(0, 2'b00, 0, 32'h31, 0).rdata, 32'h000000F0);
    issue(0, 2'b01, 1, 32'h32, 32'h0, 1, 0);
    wait_done();
    issue(0, 2'b01, 0, 32'h32, 32'h0, 1, 0);
    wait_done();
    issue(0, 2'b00, 1, 32'h30, 32'h0, 1, 0);
    wait_done();
    issue(0, 2'b00, 0, 32'h31, 32'h0, 1, 0);
    wait_done();

    // Rejected requests
    issue(1, 2'b10, 0, 32'h22, 32'hCAFEF00D, 1, 0);
    wait_done();
    issue(0, 2'b01, 0, 32'h41, 32'h0, 1, 0);
    wait_done();
    issue(0, 2'b10, 0, 32'h0004_0000, 32'h0, 1, 0);
    wait_done();
    issue(0, 2'b11, 0, 32'h10, 32'h0, 1, 0);
    wait_done();
    check("ram_after_err_store", ram[8], 32'h1122AA44);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 1, 0);
    wait_done();

    // Reset during the read phase of a byte store
    issue(1, 2'b10, 0, 32'h50, 32'h55555555, 1, 0);
    wait_done();
    issue(1, 2'b00, 0, 32'h50, 32'h000000AA, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus.req_ready_o), 32'h1);
    repeat (6) @(negedge clk);
    check("ram_rmw_aborted", ram[20], 32'h55555555);

    // Reset with a request pending: not accepted
    reset            = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_size_i   = 2'b10;
    bus.req_addr_i   = 32'h10;
    bus.req_valid_i  = 1'b1;
    #1;
    check("ready_in_reset", 32'(bus.req_ready_o), 32'h0);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    reset           = 1'b0;
    repeat (6) @(negedge clk);

    // Back-to-back with valid held high
    b2b_mode = 1;
    for (int i = 0; i < 16; i++) issue(1, 2'b10, 0, 32'(i * 4), 32'(i), 1, 1);
    for (int i = 0; i < 16; i++) issue(0, 2'b10, 0, 32'(i * 4), 32'h0, 1, (i != 15));
    wait_done();
    b2b_mode = 0;
    check("ram_b2b_last", ram[15], 32'd15);

    repeat (4) @(negedge clk);
    check("resp_queue_drained", 32'(exp_resp_q.size()), 32'h0);
    check("write_queue_drained", 32'(exp_wr_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
